// File: rtl/pattern_seq_pkg.sv
// Shared definitions for the pattern vector sequencer.
//   seq_state_t        : sequencer FSM states
//   DEFAULT_MISR_POLY  : default MISR feedback polynomial
//   DEFAULT_MISR_SEED  : default MISR start value
//   misr_next()        : one MISR compression step (shift, feedback, fold in data)
package pattern_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DUT_RST,
      ST_LOAD,
      ST_SETTLE,
      ST_CAPTURE,
      ST_DONE
   } seq_state_t;

   localparam logic [15:0] DEFAULT_MISR_POLY = 16'h1021;
   localparam logic [15:0] DEFAULT_MISR_SEED = 16'hFFFF;

   // Shift left one place, apply the polynomial when the bit shifted out was
   // set, then fold the (already zero-extended) netlist outputs into the value.
   function automatic logic [15:0] misr_next(input logic [15:0] sig,
                                             input logic [15:0] data,
                                             input logic [15:0] poly);
      misr_next = {sig[14:0], 1'b0} ^ (sig[15] ? poly : 16'h0000) ^ data;
   endfunction

endpackage

// File: rtl/pattern_misr.sv
// 16-bit multiple-input signature register compressing netlist outputs.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset, register returns to SEED
//   load_seed : reload SEED (start of a run), takes priority over enable
//   enable    : fold data into the signature this cycle
//   data      : netlist primary outputs, OUT_W bits (OUT_W <= 16)
//   sig       : current signature
module pattern_misr
   import pattern_seq_pkg::*;
#(
   parameter int          OUT_W = 8,
   parameter logic [15:0] POLY  = DEFAULT_MISR_POLY,
   parameter logic [15:0] SEED  = DEFAULT_MISR_SEED
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_seed,
   input  logic             enable,
   input  logic [OUT_W-1:0] data,
   output logic [15:0]      sig
);

   logic [15:0] data_ext;

   // Zero-extend the output bus; written this way so OUT_W == 16 needs no
   // special case.
   always_comb begin
      data_ext = '0;
      data_ext[OUT_W-1:0] = data;
   end

   // Signature register: seed on reset or run start, compress when enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig <= SEED;
      end else if (load_seed) begin
         sig <= SEED;
      end else if (enable) begin
         sig <= misr_next(sig, data_ext, POLY);
      end
   end

endmodule

// File: rtl/pattern_vector_sequencer.sv
// Drives one merged pattern netlist through a run of NUM_VEC input vectors:
// resets the netlist, applies each streamed vector, waits SETTLE_CYC clocks,
// then compresses the netlist outputs into a 16-bit MISR signature.
//   blif_clk_net   : clock, rising edge
//   blif_reset_net : asynchronous active-low reset
//   start          : begin a run (honoured only when idle, ignored with abort)
//   abort          : abandon the current run, back to idle next cycle
//   vec_valid      : vector source has data
//   vec_data       : vector payload (IN_W bits)
//   vec_ready      : a vector is accepted this cycle when vec_valid is high
//   dut_in         : registered drive to the netlist inputs
//   dut_out        : netlist outputs (OUT_W bits)
//   dut_reset_n    : active-low reset to the netlist
//   busy           : high whenever a run is in progress
//   done           : one-cycle pulse when a run completes
//   signature      : MISR value, held after completion or abort
//   vec_cnt        : vectors captured in the current/last run
module pattern_vector_sequencer
   import pattern_seq_pkg::*;
#(
   parameter int          IN_W       = 11,
   parameter int          OUT_W      = 8,
   parameter int          NUM_VEC    = 16,
   parameter int          SETTLE_CYC = 2,
   parameter logic [15:0] MISR_POLY  = DEFAULT_MISR_POLY,
   parameter logic [15:0] MISR_SEED  = DEFAULT_MISR_SEED
) (
   input  logic                           blif_clk_net,
   input  logic                           blif_reset_net,
   input  logic                           start,
   input  logic                           abort,
   input  logic                           vec_valid,
   input  logic [IN_W-1:0]                vec_data,
   output logic                           vec_ready,
   output logic [IN_W-1:0]                dut_in,
   input  logic [OUT_W-1:0]               dut_out,
   output logic                           dut_reset_n,
   output logic                           busy,
   output logic                           done,
   output logic [15:0]                    signature,
   output logic [$clog2(NUM_VEC+1)-1:0]   vec_cnt
);

   localparam int CNT_W = $clog2(NUM_VEC + 1);
   localparam int SET_W = $clog2(SETTLE_CYC + 1);

   seq_state_t       state;
   seq_state_t       state_next;
   logic [SET_W-1:0] settle_cnt;
   logic [CNT_W-1:0] vec_cnt_inc;

   logic load_seed;
   logic misr_en;
   logic clr_cnt;
   logic inc_cnt;
   logic clr_dut_in;
   logic load_vec;
   logic dec_settle;

   assign vec_cnt_inc = vec_cnt + CNT_W'(1);

   // State register.
   always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
      if (!blif_reset_net) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and datapath strobes. An abort outside IDLE overrides every
   // other transition and suppresses all strobes, so the signature, vector
   // count and dut_in are left exactly as they were.
   always_comb begin
      state_next = state;
      load_seed  = 1'b0;
      misr_en    = 1'b0;
      clr_cnt    = 1'b0;
      inc_cnt    = 1'b0;
      clr_dut_in = 1'b0;
      load_vec   = 1'b0;
      dec_settle = 1'b0;
      if (abort && (state != ST_IDLE)) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start && !abort) begin
                  load_seed  = 1'b1;
                  clr_cnt    = 1'b1;
                  state_next = ST_DUT_RST;
               end
            end
            ST_DUT_RST: begin
               clr_dut_in = 1'b1;
               state_next = ST_LOAD;
            end
            ST_LOAD: begin
               if (vec_valid) begin
                  load_vec   = 1'b1;
                  state_next = ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               dec_settle = 1'b1;
               if (settle_cnt == SET_W'(1)) begin
                  state_next = ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               misr_en = 1'b1;
               inc_cnt = 1'b1;
               if (vec_cnt_inc == CNT_W'(NUM_VEC)) begin
                  state_next = ST_DONE;
               end else begin
                  state_next = ST_LOAD;
               end
            end
            ST_DONE: begin
               state_next = ST_IDLE;
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   // Settle counter, vector counter and the registered netlist input drive.
   always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
      if (!blif_reset_net) begin
         settle_cnt <= '0;
         vec_cnt    <= '0;
         dut_in     <= '0;
      end else begin
         if (clr_cnt) begin
            vec_cnt <= '0;
         end else if (inc_cnt) begin
            vec_cnt <= vec_cnt_inc;
         end
         if (clr_dut_in) begin
            dut_in <= '0;
         end else if (load_vec) begin
            dut_in <= vec_data;
         end
         if (load_vec) begin
            settle_cnt <= SET_W'(SETTLE_CYC);
         end else if (dec_settle) begin
            settle_cnt <= settle_cnt - SET_W'(1);
         end
      end
   end

   pattern_misr #(
      .OUT_W (OUT_W),
      .POLY  (MISR_POLY),
      .SEED  (MISR_SEED)
   ) u_misr (
      .clk       (blif_clk_net),
      .rst_n     (blif_reset_net),
      .load_seed (load_seed),
      .enable    (misr_en),
      .data      (dut_out),
      .sig       (signature)
   );

   // The netlist reset follows the sequencer reset combinationally so it drops
   // immediately when reset is asserted mid-run. vec_ready is masked by abort
   // so an abandoned LOAD cycle never looks like a consumed vector.
   assign dut_reset_n = blif_reset_net && (state != ST_DUT_RST);
   assign vec_ready   = (state == ST_LOAD) && !abort;
   assign busy        = (state != ST_IDLE);
   assign done        = (state == ST_DONE);

endmodule

// File: tb/tb_pattern_vector_sequencer.sv
// Self-checking bench for pattern_vector_sequencer. A stand-in netlist with
// one register stage produces dut_out from dut_in; a behavioural run model
// predicts every output each cycle, and directed runs pin latency, handshake
// counts, abort, restart and reset behaviour with hand-computed values.
module tb_pattern_vector_sequencer;

   localparam int          NV   = 16;
   localparam int          SC   = 2;
   localparam logic [15:0] POLY = 16'h1021;
   localparam logic [15:0] SEED = 16'hFFFF;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic        vec_valid;
   logic [10:0] vec_data;
   logic        vec_ready;
   logic [10:0] dut_in;
   logic [7:0]  dut_out;
   logic        dut_reset_n;
   logic        busy;
   logic        done;
   logic [15:0] signature;
   logic [4:0]  vec_cnt;

   logic        start1;
   logic        vec_valid1 = 1'b1;
   logic [10:0] vec_data1  = '0;
   logic        vec_ready1;
   logic [10:0] dut_in1;
   logic [7:0]  dut_out1   = '0;
   logic        dut_reset_n1;
   logic        busy1;
   logic        done1;
   logic [15:0] signature1;
   logic [0:0]  vec_cnt1;
   logic        abort1     = 1'b0;

   int          n_checks = 0;
   int          n_pass   = 0;

   logic [10:0] vtab [16];
   int          src_idx   = 0;
   int          hs_cnt    = 0;
   int          stall_cfg = 0;
   int          stall_left = 0;

   always #5 clk = ~clk;

   pattern_vector_sequencer dut (
      .blif_clk_net   (clk),
      .blif_reset_net (rst_n),
      .start          (start),
      .abort          (abort),
      .vec_valid      (vec_valid),
      .vec_data       (vec_data),
      .vec_ready      (vec_ready),
      .dut_in         (dut_in),
      .dut_out        (dut_out),
      .dut_reset_n    (dut_reset_n),
      .busy           (busy),
      .done           (done),
      .signature      (signature),
      .vec_cnt        (vec_cnt)
   );

   pattern_vector_sequencer #(.NUM_VEC(1)) dut1 (
      .blif_clk_net   (clk),
      .blif_reset_net (rst_n),
      .start          (start1),
      .abort          (abort1),
      .vec_valid      (vec_valid1),
      .vec_data       (vec_data1),
      .vec_ready      (vec_ready1),
      .dut_in         (dut_in1),
      .dut_out        (dut_out1),
      .dut_reset_n    (dut_reset_n1),
      .busy           (busy1),
      .done           (done1),
      .signature      (signature1),
      .vec_cnt        (vec_cnt1)
   );

   // Stand-in netlist: one registered stage mixing the 11 inputs onto 8 outputs.
   function automatic logic [7:0] nl_fn(input logic [10:0] v);
      return v[7:0] ^ {v[10:8], v[10:6]};
   endfunction

   logic [7:0] nl_q;
   always @(posedge clk or negedge dut_reset_n) begin
      if (!dut_reset_n) nl_q <= '0;
      else              nl_q <= nl_fn(dut_in);
   end
   assign dut_out = nl_q;

   // Reference MISR step written as a 17-bit shift with conditional feedback.
   function automatic logic [15:0] ref_misr(input logic [15:0] s, input logic [7:0] d);
      logic [16:0] t;
      t = {s, 1'b0};
      if (t[16]) t[15:0] = t[15:0] ^ POLY;
      return t[15:0] ^ {8'h00, d};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Behavioural run model: a run is a reset cycle followed by NV vectors,
   // each one wait-for-data slot, SC settle slots and one capture slot, then
   // a completion cycle. It is stepped at every rising edge and compared
   // against the DUT at every falling edge.
   bit          m_run, m_rst, m_done;
   int          m_slot, m_n;
   logic [10:0] m_in;
   logic [15:0] m_sig;

   task automatic modelReset();
      m_run = 0; m_rst = 0; m_done = 0; m_slot = 0; m_n = 0;
      m_in = '0; m_sig = SEED;
   endtask

   initial begin
      modelReset();
      forever begin
         @(posedge clk);
         if (!rst_n) modelReset();
         else if (!m_run) begin
            if (start && !abort) begin
               m_run = 1; m_rst = 1; m_slot = 0; m_n = 0; m_sig = SEED;
            end
         end else if (abort) begin
            m_run = 0; m_rst = 0; m_done = 0;
         end else if (m_done) begin
            m_run = 0; m_done = 0;
         end else if (m_rst) begin
            m_rst = 0; m_in = '0; m_slot = 0;
         end else if (m_slot == 0) begin
            if (vec_valid) begin m_in = vec_data; m_slot = 1; end
         end else if (m_slot <= SC) begin
            m_slot++;
         end else begin
            m_sig = ref_misr(m_sig, nl_fn(m_in));
            m_n++;
            m_slot = 0;
            if (m_n == NV) m_done = 1;
         end
         @(negedge clk);
         if (!rst_n) modelReset();
         checkOutput("busy", busy, m_run);
         checkOutput("done", done, m_done);
         checkOutput("vec_ready", vec_ready,
                     m_run && !m_rst && !m_done && (m_slot == 0) && !abort);
         checkOutput("dut_reset_n", dut_reset_n, rst_n && !(m_run && m_rst));
         checkOutput("dut_in", dut_in, m_in);
         checkOutput("signature", signature, m_sig);
         checkOutput("vec_cnt", vec_cnt, m_n);
      end
   end

   // Vector source: presents vtab[src_idx], counts handshakes, and can hold
   // vec_valid low for stall_cfg LOAD cycles while offering the third vector.
   initial begin
      bit take;
      vec_valid = 1'b1;
      vec_data  = '0;
      forever begin
         @(negedge clk);
         if (!busy) begin
            src_idx = 0; hs_cnt = 0; stall_left = stall_cfg; vec_data = vtab[0];
         end
         if (stall_left > 0 && src_idx == 2 && vec_ready) begin
            vec_valid = 1'b0;
            stall_left--;
         end else begin
            vec_valid = 1'b1;
         end
         take = vec_ready && vec_valid;
         if (take) hs_cnt++;
         @(posedge clk);
         #1;
         if (take) begin
            src_idx++;
            vec_data = vtab[src_idx % 16];
         end
      end
   end

   // One complete run on the main DUT; reports start-to-done cycle count,
   // final signature, cycles with dut_reset_n low and handshake count.
   task automatic applyStimulus(input bit hold_start, input int stall_n,
                                output int cyc, output logic [15:0] sig,
                                output int rst_low, output int hs);
      stall_cfg = stall_n;
      @(negedge clk); @(negedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 if (!hold_start) start = 1'b0;
      cyc = 0; rst_low = 0;
      while (cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (!dut_reset_n) rst_low++;
         if (done) break;
      end
      #1;
      start = 1'b0;
      sig = signature;
      hs = hs_cnt;
      if (!done) checkOutput("done_timeout", 0, 1);
   endtask

   initial begin
      int          cyc, rl, hs;
      logic [15:0] sig_a, sig_b, exp_full, exp_one;
      bit          saw_done;

      for (int i = 0; i < 16; i++) vtab[i] = 11'((i * 389 + 91) % 2048);
      exp_full = SEED;
      for (int i = 0; i < NV; i++) exp_full = ref_misr(exp_full, nl_fn(vtab[i]));
      exp_one = ref_misr(SEED, nl_fn(vtab[0]));

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; start1 = 1'b0;

      // Reset state, then release.
      repeat (3) @(negedge clk);
      #1;
      checkOutput("rst_signature", signature, 16'hFFFF);
      checkOutput("rst_dut_reset_n", dut_reset_n, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_dut_in", dut_in, 0);
      rst_n = 1'b1;
      #1 checkOutput("rel_dut_reset_n", dut_reset_n, 1);
      repeat (2) @(negedge clk);

      // Single-vector instance with all-zero netlist outputs.
      #1 start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      cyc = 0;
      while (cyc < 50) begin
         @(negedge clk);
         cyc++;
         if (done1) break;
      end
      checkOutput("one_done_cycle", cyc, 6);
      checkOutput("one_signature", signature1, 16'hEFDF);
      checkOutput("one_vec_cnt", vec_cnt1, 1);

      // Full run with start held high the whole time.
      applyStimulus(1, 0, cyc, sig_a, rl, hs);
      checkOutput("full_done_cycle", cyc, 66);
      checkOutput("full_handshakes", hs, 16);
      checkOutput("full_rst_low_cycles", rl, 1);
      checkOutput("full_signature", sig_a, exp_full);
      checkOutput("full_vec_cnt", vec_cnt, 16);
      @(negedge clk);
      checkOutput("no_restart_busy", busy, 0);

      // Five-cycle source stall on vector 3.
      applyStimulus(0, 5, cyc, sig_b, rl, hs);
      checkOutput("stall_done_cycle", cyc, 71);
      checkOutput("stall_signature", sig_b, exp_full);
      checkOutput("stall_handshakes", hs, 16);
      stall_cfg = 0;

      // Abort during the settle of vector 2.
      @(negedge clk); @(negedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #2;
         if (hs_cnt >= 2) break;
      end
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_vec_cnt", vec_cnt, 1);
      checkOutput("abort_dut_in", dut_in, vtab[1]);
      saw_done = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done) saw_done = 1;
         checkOutput("abort_sig_frozen", signature, exp_one);
      end
      checkOutput("abort_no_done", saw_done, 0);

      // Restart after abort reseeds the signature and count.
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      checkOutput("reseed_signature", signature, 16'hFFFF);
      checkOutput("reseed_vec_cnt", vec_cnt, 0);
      checkOutput("reseed_dut_reset_n", dut_reset_n, 0);
      cyc = 0;
      while (cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (done) break;
      end
      checkOutput("reseed_done_cycle", cyc, 66);
      checkOutput("reseed_final_sig", signature, exp_full);

      // Reset asserted mid-run.
      @(negedge clk); @(negedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_dut_reset_n", dut_reset_n, 0);
      checkOutput("midrst_done", done, 0);
      checkOutput("midrst_signature", signature, 16'hFFFF);
      checkOutput("midrst_vec_cnt", vec_cnt, 0);
      checkOutput("midrst_dut_in", dut_in, 0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("post_busy", busy, 0);
      checkOutput("post_dut_reset_n", dut_reset_n, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
